// File: rtl/serial_frame_pkg.sv
// Shared types, default parameters and the port-to-channel decode used by
// serial_frame_router and its start detector.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_PORT = 2'd1,
    GET_CNT  = 2'd2,
    XFER     = 2'd3
  } state_t;

  localparam int              DEF_START_LEN     = 4;
  localparam logic [3:0]      DEF_START_PATTERN = 4'b0111;
  localparam int              DEF_PORT_W        = 2;
  localparam int              DEF_NUM_CH        = 3;
  localparam int              DEF_CNT_W         = 4;
  localparam int              MAX_CH            = 32;

  // Port N selects channel bit N-1; port 0 selects nothing.
  function automatic logic [MAX_CH-1:0] onehot_port(input logic [7:0] port);
    onehot_port = (port == 8'd0) ? '0 : (MAX_CH'(1) << (port - 8'd1));
  endfunction

endpackage

// File: rtl/serial_frame_router_start_detector.sv
// Sliding-window start-pattern detector; the window includes the bit being
// sampled this edge so a match is reported in the same cycle it completes.
module start_detector
  import serial_frame_pkg::*;
#(
  parameter int                   START_LEN     = DEF_START_LEN,
  parameter logic [START_LEN-1:0] START_PATTERN = START_LEN'(DEF_START_PATTERN)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic ser_in,
  output logic match
);

  logic [START_LEN-1:0] sr_q, sr_d, sr_shift;

  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sr_shift = START_LEN'({sr_q, ser_in});
    sr_d     = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d = sr_shift;
    end
  end

  assign match = en && (sr_shift == START_PATTERN);

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/serial_frame_router.sv
// Serial frame router: finds a start pattern, reads port and length fields,
// then forwards the payload bits with a one-hot channel select.
module serial_frame_router
  import serial_frame_pkg::*;
#(
  parameter int                   START_LEN     = DEF_START_LEN,
  parameter logic [START_LEN-1:0] START_PATTERN = START_LEN'(DEF_START_PATTERN),
  parameter int                   PORT_W        = DEF_PORT_W,
  parameter int                   NUM_CH        = DEF_NUM_CH,
  parameter int                   CNT_W         = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  output logic              ser_out,
  output logic              ser_valid,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [PORT_W-1:0] port_o
);

  localparam int FIELD_W = (PORT_W > CNT_W) ? PORT_W : CNT_W;
  localparam int BC_W    = $clog2(FIELD_W + 1);

  state_t              state_q, state_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FIELD_W-1:0]  acc_q, acc_d, acc_shift;
  logic [PORT_W-1:0]   port_q, port_d, port_field;
  logic [CNT_W-1:0]    cnt_field;
  logic                port_ok_q, port_ok_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                ser_out_q, ser_out_d;
  logic                ser_valid_q, ser_valid_d;
  logic [NUM_CH-1:0]   ch_sel_q, ch_sel_d;
  logic                done_q, done_d;
  logic                frame_err_q, frame_err_d;
  logic                match, det_en, det_clr;

  start_detector #(
    .START_LEN     (START_LEN),
    .START_PATTERN (START_PATTERN)
  ) u_start_detector (
    .clk    (clk),
    .rst    (rst),
    .en     (det_en),
    .clr    (det_clr),
    .ser_in (ser_in),
    .match  (match)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    acc_shift   = FIELD_W'({acc_q, ser_in});
    acc_d       = acc_q;
    port_field  = acc_shift[PORT_W-1:0];
    cnt_field   = acc_shift[CNT_W-1:0];
    port_d      = port_q;
    port_ok_d   = port_ok_q;
    remaining_d = remaining_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ch_sel_d    = '0;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (match) begin
          state_d   = GET_PORT;
          bit_cnt_d = '0;
          acc_d     = '0;
        end
      end

      GET_PORT: begin
        acc_d     = acc_shift;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == BC_W'(PORT_W - 1)) begin
          port_d    = port_field;
          port_ok_d = (port_field != '0) && (int'(port_field) <= NUM_CH);
          bit_cnt_d = '0;
          acc_d     = '0;
          state_d   = GET_CNT;
        end
      end

      GET_CNT: begin
        acc_d     = acc_shift;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == BC_W'(CNT_W - 1)) begin
          remaining_d = cnt_field;
          bit_cnt_d   = '0;
          acc_d       = '0;
          if (cnt_field == '0) begin
            done_d      = 1'b1;
            frame_err_d = !port_ok_q;
            state_d     = IDLE;
          end else begin
            state_d = XFER;
          end
        end
      end

      XFER: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (port_ok_q) begin
          ser_out_d   = ser_in;
          ser_valid_d = 1'b1;
          ch_sel_d    = NUM_CH'(onehot_port(8'(port_q)));
        end
        // remaining is at least 1 on entry, so exiting at 1 never underflows.
        if (remaining_q == CNT_W'(1)) begin
          done_d      = 1'b1;
          frame_err_d = !port_ok_q;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    det_en  = (state_q == IDLE);
    det_clr = (state_q != IDLE) && (state_d == IDLE);
  end

  // NOTE: every flop, including the held port field, is cleared by reset so
  // an abandoned frame leaves no stale status behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      port_q      <= '0;
      port_ok_q   <= 1'b0;
      remaining_q <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ch_sel_q    <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      port_q      <= port_d;
      port_ok_q   <= port_ok_d;
      remaining_q <= remaining_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ch_sel_q    <= ch_sel_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ch_sel    = ch_sel_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
  assign port_o    = port_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_router.sv
// Scoreboard bench for serial_frame_router: frames push expected output
// events, a negedge monitor pops and compares each event the DUT presents.
module tb_serial_frame_router;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       ser_out;
  logic       ser_valid;
  logic [2:0] ch_sel;
  logic       busy;
  logic       done;
  logic       frame_err;
  logic [1:0] port_o;

  typedef struct packed {
    logic       valid;
    logic       out;
    logic [2:0] ch;
    logic       done;
    logic       err;
    logic [1:0] port;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_act, mon_exp;
  int   checks = 0;
  int   errors = 0;

  serial_frame_router dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ch_sel    (ch_sel),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .port_o    (port_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic obs_t mk(input logic v, input logic o, input logic [2:0] ch,
                              input logic d, input logic e, input logic [1:0] p);
    mk = '{valid: v, out: o, ch: ch, done: d, err: e, port: p};
  endfunction

  // Monitor: any cycle with valid, done or frame_err is one scoreboard event.
  always @(negedge clk) begin
    if (rst === 1'b1 && (ser_valid || done || frame_err)) begin
      mon_act = '{valid: ser_valid, out: ser_out, ch: ch_sel, done: done,
                  err: frame_err, port: port_o};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got=%0h expected=none at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  task automatic send_bit(input logic b);
    ser_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  // Sends start + port + count + payload and queues the expected events.
  task automatic frame(input logic [1:0] port, input logic [3:0] cnt, input logic [31:0] pay);
    logic       vp;
    logic [2:0] oh;
    vp = (port != 2'd0) && (port <= 2'd3);
    oh = vp ? (3'b001 << (port - 2'd1)) : 3'b000;
    if (cnt == 4'd0) begin
      exp_q.push_back(mk(1'b0, 1'b0, 3'b000, 1'b1, !vp, port));
    end else if (!vp) begin
      exp_q.push_back(mk(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, port));
    end else begin
      for (int i = 0; i < int'(cnt); i++)
        exp_q.push_back(mk(1'b1, pay[int'(cnt) - 1 - i], oh, i == int'(cnt) - 1, 1'b0, port));
    end
    send_bits(32'h7, 4);
    send_bits(32'(port), 2);
    send_bits(32'(cnt), 4);
    send_bits(pay, int'(cnt));
  endtask

  initial begin
    rst    = 1'b0;
    ser_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'd0, ser_out, ser_valid, ch_sel, done, frame_err, port_o}, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    idle(3);

    // Basic frame: port 1, three bits 1,0,1.
    exp_q.push_back(mk(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 2'd1));
    exp_q.push_back(mk(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'd1));
    exp_q.push_back(mk(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 2'd1));
    send_bits(32'b0111_01_0011_101, 13);
    check("basic_busy_low", 32'(busy), 32'd0);
    check("basic_port_o", 32'(port_o), 32'd1);
    idle(4);

    // Channel 3, maximum length of 15 alternating bits.
    frame(2'd3, 4'd15, 32'b101010101010101);
    idle(4);
    check("ch3_port_o", 32'(port_o), 32'd3);

    // Invalid port 0: bits consumed, done and frame_err together.
    frame(2'd0, 4'd2, 32'b11);
    idle(4);
    check("invalid_port_o", 32'(port_o), 32'd0);

    // Zero-length frame on port 2.
    frame(2'd2, 4'd0, 32'd0);
    idle(4);
    check("zero_cnt_port_o", 32'(port_o), 32'd2);

    // Start pattern inside the payload must not retrigger.
    frame(2'd1, 4'd5, 32'b01110);
    idle(6);

    // Overlapping preamble 0011 then 0111: one match, single bit 0.
    send_bits(32'b0011, 4);
    frame(2'd1, 4'd1, 32'b0);
    idle(4);

    // Async reset during payload bit 2 of a 5-bit frame.
    exp_q.push_back(mk(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 2'd1));
    send_bits(32'b0111_01_0101, 10);
    check("busy_mid_frame", 32'(busy), 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    #1 rst = 1'b0;
    #1;
    check("reset_mid_xfer",
          {23'd0, ser_out, ser_valid, ch_sel, done, frame_err, port_o, busy}, 32'd0);
    ser_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    frame(2'd2, 4'd3, 32'b011);
    idle(6);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_router.md
Name: serial_frame_router

Overview:
- Parametrised successor to the CA4 serial receiver/demultiplexer.
- Scans a single-bit serial stream for a configurable start pattern, then reads a port field and a bit-count field.
- Forwards the following payload bits to a registered serial output, with a one-hot channel select for up to NUM_CH destinations.
- Flags frames addressed to invalid ports; provides busy, done and error status for the surrounding top level.

Parameters:
START_LEN, 4, width of start pattern in bits
START_PATTERN, 4'b0111, start pattern, first-received bit is MSB
PORT_W, 2, width of port field
NUM_CH, 3, number of output channels (1..2**PORT_W-1)
CNT_W, 4, width of payload-count field

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
ser_in  input  1  serial data in, sampled each rising edge
ser_out  output  1  registered payload bit
ser_valid  output  1  ser_out carries a payload bit this cycle
ch_sel  output  NUM_CH  one-hot destination of current payload bit
busy  output  1  high while state is not IDLE
done  output  1  one-cycle pulse, frame finished
frame_err  output  1  one-cycle pulse, invalid port
port_o  output  PORT_W  port of current/last frame, held until next frame

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; shift register, counters and all outputs cleared to 0, including port_o. Reset mid-frame abandons the frame with no done/frame_err.
- States: IDLE, GET_PORT, GET_CNT, XFER.
- IDLE:
  - Shift ser_in into a START_LEN shift register each cycle.
  - A match occurs when the register contents, including the bit sampled this edge, equal START_PATTERN. On match, next state is GET_PORT. Overlapping matches are allowed.
- GET_PORT:
  - Shift in PORT_W bits, MSB first. port_o updates at the edge sampling the last bit.
  - port==0 or port>NUM_CH is invalid.
  - Next state is GET_CNT.
- GET_CNT:
  - Shift in CNT_W bits, MSB first. On the last bit, remaining=count.
  - count==0: pulse done the next cycle, return to IDLE. frame_err also pulses that cycle if the port is invalid.
  - Otherwise: next state is XFER.
- XFER:
  - Each edge samples ser_in and decrements remaining.
  - Valid port: the next cycle drives ser_out=sampled bit, ser_valid=1, ch_sel=1<<(port-1).
  - Invalid port: bits are consumed; ser_out=0, ser_valid=0, ch_sel=0.
  - When remaining reaches 0: state goes to IDLE. done pulses in the same cycle as the last payload bit's ser_valid. frame_err pulses that same cycle if the port is invalid.
- Latency: payload bit sampled at edge k appears on ser_out during cycle k+1. ser_valid/ch_sel drop to 0 one cycle after the last bit.
- On any exit to IDLE the start shift register is cleared, so payload/header bits never contribute to a match. Detection restarts with the first bit sampled in IDLE.
- Count field: unsigned, maximum frame 2**CNT_W-1 payload bits. No wrap; remaining never underflows.
- busy is combinational from state.

Decomposition:
- Package serial_frame_pkg holds:
  - state enum state_t {IDLE, GET_PORT, GET_CNT, XFER};
  - default-parameter localparams;
  - function onehot_port(port) returning ch_sel.
- Sub-module start_detector (params START_LEN, START_PATTERN):
  - inputs clk, rst, en, clr, ser_in; output match;
  - holds the shift register and comparison.
- FSM, field counters and output registers stay in serial_frame_router.

Test Plan:
- Basic frame: after reset, drive 0111,01,0011,1,0,1 (one bit/cycle) -> ch_sel=3'b001 and ser_valid=1 for 3 cycles, ser_out=1,0,1, done pulses with third bit, port_o=1, busy low next cycle.
- Channel 3, max length: 0111,11,1111 then 15 alternating bits starting 1 -> ch_sel=3'b100 for 15 cycles, ser_out matches input delayed one cycle, single done.
- Invalid port: 0111,00,0010,1,1 -> ser_valid never high, ch_sel=0, frame_err and done pulse together after second payload bit, port_o=0.
- Zero count and pattern isolation: 0111,10,0000 then payload-like 0111 -> done pulse one cycle after count, no ser_valid. Stream 1,0111 (with leading 0 preceding) yields exactly one match; pattern inside a 5-bit payload 01110 does not retrigger.
- Overlap/preamble: 00110111,01,0001,0 -> match on final 0111 only, single payload bit 0 on channel 1.
- Async reset mid-XFER: pull rst low between clock edges during payload bit 2 of a 5-bit frame -> all outputs 0 immediately, no done. A following full frame after rst release is routed correctly.
